reg_readout_seq: RTL and testbench

- Reader side of the calculator's register bank. On START, walks register addresses 0..DEPTH-1 through the bank's asynchronous read port and streams each value out over a valid/ready handshake.
- Used to dump operand/accumulator registers to the display/serial front end after a calculation.
- Pure sequencer: owns no storage except the output holding register, the address counter and the FSM.

---
 rtl/reg_readout_seq_pkg.sv | 19 +
 rtl/readout_addr_ctr.sv | 31 +++
 rtl/reg_readout_seq.sv | 100 ++++++++++
 tb/tb_reg_readout_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_readout_seq_pkg.sv
// ==== reg_readout_seq_pkg: shared state encoding and default widths (rev 1.0) ====
`default_nettype none

package reg_readout_seq_pkg;

  localparam int RDO_N     = 8;
  localparam int RDO_DEPTH = 4;
  localparam int RDO_AW    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/readout_addr_ctr.sv
// ==== readout_addr_ctr: AW-bit scan address counter with clear/increment (rev 1.0) ====
`default_nettype none

module readout_addr_ctr
  import reg_readout_seq_pkg::*;
#(
  parameter int AW    = RDO_AW,
  parameter int DEPTH = RDO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] addr,
  output logic          is_last
);

  assign is_last = (addr == AW'(DEPTH - 1));

  // Holding at the last address keeps the counter from ever wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      addr <= '0;
    end else if (inc && !is_last) begin
      addr <= addr + AW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_readout_seq.sv
// ==== reg_readout_seq: scans register bank 0..DEPTH-1 onto a valid/ready stream (rev 1.0) ====
// Optional macro READOUT_PARITY_EN adds OUT_PAR, the registered XOR reduction of OUT_DATA.
`default_nettype none

module reg_readout_seq
  import reg_readout_seq_pkg::*;
#(
  parameter int N     = RDO_N,
  parameter int DEPTH = RDO_DEPTH,
  parameter int AW    = RDO_AW
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          START,
  output logic [AW-1:0] RD_ADDR,
  input  logic [N-1:0]  RD_DATA,
  output logic [N-1:0]  OUT_DATA,
  output logic [AW-1:0] OUT_ADDR,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          OUT_LAST,
  output logic          BUSY,
`ifdef READOUT_PARITY_EN
  output logic          OUT_PAR,
`endif
  output logic          DONE
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr;
  logic          is_last;
  logic          handshake;

  assign handshake = (state == SEND) && OUT_READY;

  readout_addr_ctr #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_addr_ctr (
    .clk     (CLK),
    .rst     (CLR),
    .clr     (state == IDLE),
    .inc     (handshake),
    .addr    (addr),
    .is_last (is_last)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = FETCH;
      FETCH:   state_nxt = SEND;
      SEND: begin
        if (handshake) state_nxt = is_last ? FINISH : FETCH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bank data is snapshotted here so later RD_DATA changes cannot disturb SEND.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      OUT_DATA <= '0;
      OUT_ADDR <= '0;
      OUT_LAST <= 1'b0;
    end else if (state == FETCH) begin
      OUT_DATA <= RD_DATA;
      OUT_ADDR <= addr;
      OUT_LAST <= is_last;
    end
  end

`ifdef READOUT_PARITY_EN
  always_ff @(posedge CLK) begin
    if (CLR) begin
      OUT_PAR <= 1'b0;
    end else if (state == FETCH) begin
      OUT_PAR <= ^RD_DATA;
    end
  end
`endif

  assign RD_ADDR   = (state == IDLE) ? '0 : addr;
  assign OUT_VALID = (state == SEND);
  assign BUSY      = (state != IDLE);
  assign DONE      = (state == FINISH);

endmodule

`default_nettype wire

// File: tb/tb_reg_readout_seq.sv
// ==== tb_reg_readout_seq: directed checks for reg_readout_seq (DEPTH=4 and DEPTH=1) (rev 1.0) ====
`default_nettype none

module tb_reg_readout_seq;

  logic       clk = 1'b0;
  logic       clr;
  logic       start_a, ready_a, start_b, ready_b;
  logic [1:0] rd_addr_a, rd_addr_b, out_addr_a, out_addr_b;
  logic [7:0] rd_data_a, rd_data_b, out_data_a, out_data_b;
  logic       valid_a, last_a, busy_a, done_a;
  logic       valid_b, last_b, busy_b, done_b;
`ifdef READOUT_PARITY_EN
  logic       par_a, par_b;
`endif

  logic [7:0] bank   [4];
  logic [7:0] bank_b [4];
  logic [7:0] exp_d  [4];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int done_snap;

  always #5 clk = ~clk;

  assign rd_data_a = bank[rd_addr_a];
  assign rd_data_b = bank_b[rd_addr_b];

  reg_readout_seq #(.N(8), .DEPTH(4), .AW(2)) dut_a (
    .CLK(clk), .CLR(clr), .START(start_a),
    .RD_ADDR(rd_addr_a), .RD_DATA(rd_data_a),
    .OUT_DATA(out_data_a), .OUT_ADDR(out_addr_a), .OUT_VALID(valid_a),
    .OUT_READY(ready_a), .OUT_LAST(last_a), .BUSY(busy_a),
`ifdef READOUT_PARITY_EN
    .OUT_PAR(par_a),
`endif
    .DONE(done_a)
  );

  reg_readout_seq #(.N(8), .DEPTH(1), .AW(2)) dut_b (
    .CLK(clk), .CLR(clr), .START(start_b),
    .RD_ADDR(rd_addr_b), .RD_DATA(rd_data_b),
    .OUT_DATA(out_data_b), .OUT_ADDR(out_addr_b), .OUT_VALID(valid_b),
    .OUT_READY(ready_b), .OUT_LAST(last_b), .BUSY(busy_b),
`ifdef READOUT_PARITY_EN
    .OUT_PAR(par_b),
`endif
    .DONE(done_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (cyc > 5000) begin
      n_err++;
      $display("FAIL watchdog: got %0d cycles expected <= 5000", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog expired");
    end
  endtask

  task automatic check_word(input string tag, input int idx, input logic [7:0] d, input logic lst);
    check_val({tag, "_valid"}, {31'd0, valid_a}, 32'd1);
    check_val({tag, "_data"}, {24'd0, out_data_a}, {24'd0, d});
    check_val({tag, "_addr"}, {30'd0, out_addr_a}, idx);
    check_val({tag, "_last"}, {31'd0, last_a}, {31'd0, lst});
  endtask

  initial begin
    bank[0] = 8'h12; bank[1] = 8'h34; bank[2] = 8'h56; bank[3] = 8'h78;
    exp_d = bank;
    bank_b[0] = 8'hA5; bank_b[1] = 8'h00; bank_b[2] = 8'h00; bank_b[3] = 8'h00;
    clr = 1'b1; start_a = 1'b0; ready_a = 1'b1; start_b = 1'b0; ready_b = 1'b1;

    // Reset state
    step(); step();
    clr = 1'b0;
    check_val("rst_valid", {31'd0, valid_a}, 32'd0);
    check_val("rst_busy",  {31'd0, busy_a},  32'd0);
    check_val("rst_done",  {31'd0, done_a},  32'd0);
    check_val("rst_data",  {24'd0, out_data_a}, 32'd0);
    check_val("rst_oaddr", {30'd0, out_addr_a}, 32'd0);
    check_val("rst_last",  {31'd0, last_a},  32'd0);
    check_val("rst_rdaddr", {30'd0, rd_addr_a}, 32'd0);

    // Full readout with OUT_READY held high
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check_val("t1_fetch_valid", {31'd0, valid_a}, 32'd0);
    check_val("t1_fetch_busy",  {31'd0, busy_a},  32'd1);
    step();
    check_word("t1_w0", 0, exp_d[0], 1'b0);
`ifdef READOUT_PARITY_EN
    check_val("t1_par_w0", {31'd0, par_a}, 32'd0);
`endif
    for (int i = 1; i < 4; i++) begin
      step();
      check_val("t1_gap_valid", {31'd0, valid_a}, 32'd0);
      check_val("t1_gap_rdaddr", {30'd0, rd_addr_a}, i);
      step();
      check_word("t1_w", i, exp_d[i], (i == 3));
`ifdef READOUT_PARITY_EN
      if (i == 1) check_val("t1_par_w1", {31'd0, par_a}, 32'd1);
`endif
    end
    step();
    check_val("t1_done", {31'd0, done_a}, 32'd1);
    check_val("t1_fin_busy", {31'd0, busy_a}, 32'd1);
    check_val("t1_fin_valid", {31'd0, valid_a}, 32'd0);
    step();
    check_val("t1_done_off", {31'd0, done_a}, 32'd0);
    check_val("t1_busy_off", {31'd0, busy_a}, 32'd0);
    check_val("t1_done_cnt", done_cnt_a, 32'd1);

    // Backpressure on word 1 with bank change, START pulse during word 2
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    check_word("t2_w0", 0, 8'h12, 1'b0);
    step();
    ready_a = 1'b0;
    step();
    check_word("t2_w1", 1, 8'h34, 1'b0);
    bank[1] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check_word("t2_hold", 1, 8'h34, 1'b0);
    end
    ready_a = 1'b1;
    step();
    check_val("t2_gap_valid", {31'd0, valid_a}, 32'd0);
    step();
    check_word("t2_w2", 2, 8'h56, 1'b0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    check_word("t2_w3", 3, 8'h78, 1'b1);
    step();
    check_val("t2_done", {31'd0, done_a}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("t2_idle_busy", {31'd0, busy_a}, 32'd0);
    end
    check_val("t2_done_cnt", done_cnt_a, 32'd2);
    bank[1] = 8'h34;

    // CLR during SEND of word 1
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(); step(); step();
    check_word("t3_w1", 1, 8'h34, 1'b0);
    done_snap = done_cnt_a;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_val("t3_valid", {31'd0, valid_a}, 32'd0);
    check_val("t3_busy",  {31'd0, busy_a},  32'd0);
    check_val("t3_done",  {31'd0, done_a},  32'd0);
    check_val("t3_data",  {24'd0, out_data_a}, 32'd0);
    check_val("t3_oaddr", {30'd0, out_addr_a}, 32'd0);
    check_val("t3_rdaddr", {30'd0, rd_addr_a}, 32'd0);
    step();
    check_val("t3_still_idle", {31'd0, busy_a}, 32'd0);
    check_val("t3_no_done", done_cnt_a, done_snap);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    check_word("t3_restart_w0", 0, 8'h12, 1'b0);
    for (int i = 0; i < 20 && !done_a; i++) step();
    check_val("t3_restart_done", {31'd0, done_a}, 32'd1);
    step();

    // Single-entry instance
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check_val("t4_fetch_valid", {31'd0, valid_b}, 32'd0);
    step();
    check_val("t4_valid", {31'd0, valid_b}, 32'd1);
    check_val("t4_data",  {24'd0, out_data_b}, 32'h0000_00A5);
    check_val("t4_addr",  {30'd0, out_addr_b}, 32'd0);
    check_val("t4_last",  {31'd0, last_b}, 32'd1);
`ifdef READOUT_PARITY_EN
    check_val("t4_par", {31'd0, par_b}, 32'd0);
`endif
    step();
    check_val("t4_done", {31'd0, done_b}, 32'd1);
    step();
    check_val("t4_busy_off", {31'd0, busy_b}, 32'd0);
    check_val("t4_done_cnt", done_cnt_b, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
